// File: rtl/ysyx_24110015_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states and request owner.
package ysyx_24110015_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/ysyx_24110015_rr_pick2.sv
// Combinational 2-way winner selection between IFU and LSU requests.
module ysyx_24110015_rr_pick2
  import ysyx_24110015_mem_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic   ifu_valid,
  input  logic   lsu_valid,
  input  owner_t last_grant,
  output logic   grant_valid,
  output owner_t grant
);

  logic lsu_wins_tie;

  // Round-robin hands a tie to whoever was not served last; fixed priority favours the LSU.
  assign lsu_wins_tie = (RR_EN != 0) ? (last_grant == OWN_IFU) : 1'b1;

  always_comb begin
    grant_valid = ifu_valid | lsu_valid;
    grant       = OWN_IFU;
    if (ifu_valid && lsu_valid) begin
      grant = lsu_wins_tie ? OWN_LSU : OWN_IFU;
    end else if (lsu_valid) begin
      grant = OWN_LSU;
    end
  end

endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// 2:1 arbiter sharing one pmem request/response port between the IFU and the LSU,
// with an optional watchdog that turns a hung response into an error.
module ysyx_24110015_mem_arbiter
  import ysyx_24110015_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err
);

  state_t                state_reg, state_next;
  owner_t                owner_reg, last_grant_reg, grant;
  logic                  grant_valid, accept, timed_out;
  logic [ADDR_W-1:0]     addr_reg;
  logic                  wen_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic [DATA_W/8-1:0]   wmask_reg;
  logic                  owner_resp_ready, resp_valid, resp_err;
  logic [DATA_W-1:0]     resp_rdata;

  ysyx_24110015_rr_pick2 #(.RR_EN(RR_EN)) u_pick (
    .ifu_valid   (ifu_req_valid),
    .lsu_valid   (lsu_req_valid),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Grants are held off while reset is asserted so nothing is accepted on the reset edge.
  assign accept = (state_reg == IDLE) && grant_valid && rst;

  assign mem_addr  = addr_reg;
  assign mem_wen   = wen_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wmask = wmask_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_IFU;
      last_grant_reg <= OWN_IFU;
      addr_reg       <= '0;
      wen_reg        <= 1'b0;
      wdata_reg      <= '0;
      wmask_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        owner_reg      <= grant;
        last_grant_reg <= grant;
        addr_reg       <= (grant == OWN_LSU) ? lsu_addr : ifu_addr;
        wen_reg        <= (grant == OWN_LSU) && lsu_wen;
        wdata_reg      <= (grant == OWN_LSU) ? lsu_wdata : '0;
        wmask_reg      <= (grant == OWN_LSU) ? lsu_wmask : '0;
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      logic [CNT_W-1:0] cnt_reg;
      logic             mem_hs;

      assign mem_hs    = mem_resp_valid && mem_resp_ready;
      assign timed_out = (cnt_reg == CNT_W'(TIMEOUT));

      // Cleared whenever outside RESP, so every RESP entry starts from zero; saturates at TIMEOUT.
      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (state_reg != RESP) begin
          cnt_reg <= '0;
        end else if (!mem_hs && !timed_out) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end else begin : g_no_wdog
      assign timed_out = 1'b0;
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    ifu_req_ready    = 1'b0;
    lsu_req_ready    = 1'b0;
    mem_req_valid    = 1'b0;
    mem_resp_ready   = 1'b0;
    resp_valid       = 1'b0;
    resp_rdata       = '0;
    resp_err         = 1'b0;
    ifu_resp_valid   = 1'b0;
    ifu_rdata        = '0;
    ifu_err          = 1'b0;
    lsu_resp_valid   = 1'b0;
    lsu_rdata        = '0;
    lsu_err          = 1'b0;
    owner_resp_ready = (owner_reg == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          ifu_req_ready = (grant == OWN_IFU);
          lsu_req_ready = (grant == OWN_LSU);
          state_next    = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = RESP;
      end
      RESP: begin
        if (timed_out) begin
          // Synthesised error; the real response, if it ever comes, is dropped in DRAIN.
          resp_valid = 1'b1;
          resp_err   = 1'b1;
          if (owner_resp_ready) state_next = DRAIN;
        end else begin
          resp_valid     = mem_resp_valid;
          resp_rdata     = mem_rdata;
          resp_err       = mem_err;
          mem_resp_ready = owner_resp_ready;
          if (mem_resp_valid && owner_resp_ready) state_next = IDLE;
        end
      end
      DRAIN: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (owner_reg == OWN_LSU) begin
      lsu_resp_valid = resp_valid;
      lsu_rdata      = resp_rdata;
      lsu_err        = resp_err;
    end else begin
      ifu_resp_valid = resp_valid;
      ifu_rdata      = resp_rdata;
      ifu_err        = resp_err;
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Self-checking bench: round-robin/watchdog arbiter plus a fixed-priority copy fed the same stimulus.
module tb_ysyx_24110015_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ifu_req_valid, ifu_resp_ready, lsu_req_valid, lsu_wen, lsu_resp_ready;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_ready, mem_resp_valid, mem_err;

  logic        ifu_req_ready, ifu_resp_valid, ifu_err, lsu_req_ready, lsu_resp_valid, lsu_err;
  logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic        mem_req_valid, mem_wen, mem_resp_ready;
  logic [3:0]  mem_wmask;

  logic        fp_ifu_req_ready, fp_ifu_resp_valid, fp_ifu_err, fp_lsu_req_ready, fp_lsu_resp_valid, fp_lsu_err;
  logic [31:0] fp_ifu_rdata, fp_lsu_rdata, fp_mem_addr, fp_mem_wdata;
  logic        fp_mem_req_valid, fp_mem_wen, fp_mem_resp_ready;
  logic [3:0]  fp_mem_wmask;

  ysyx_24110015_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  ysyx_24110015_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT(0)) dut_fp (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(fp_ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(fp_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(fp_ifu_rdata), .ifu_err(fp_ifu_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(fp_lsu_req_ready), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_resp_valid(fp_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(fp_lsu_rdata), .lsu_err(fp_lsu_err),
    .mem_req_valid(fp_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(fp_mem_addr), .mem_wen(fp_mem_wen),
    .mem_wdata(fp_mem_wdata), .mem_wmask(fp_mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_resp_ready(fp_mem_resp_ready),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  int tests = 0;
  int fails = 0;
  int last_m = 0;  // model of who was served last: 0 = IFU, 1 = LSU

  // Arbitration rule: a lone requester wins; a tie goes to the one not served last (rr) or to the LSU.
  function automatic int pick(input logic iv, input logic lv, input int last, input bit rr);
    if (iv && lv) return rr ? ((last == 0) ? 1 : 0) : 1;
    return lv ? 1 : 0;
  endfunction

  task automatic drive_quiet();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
  endtask

  // One full transaction: grant, REQ held for req_lat stalls, response after resp_lat, owner stalls rdy_lat.
  task automatic txn(input logic iv, input logic lv, input logic [31:0] ia, input logic [31:0] la,
                     input logic wen, input logic [31:0] wd, input logic [3:0] wm,
                     input int req_lat, input int resp_lat, input int rdy_lat,
                     input logic [31:0] rd, input logic er, output int got);
    int win, fwin;
    logic [31:0] ea, o_d, n_d;
    logic ewen, ov, ordy, o_v, o_e, n_v, n_e;
    logic [3:0] ewm;
    @(negedge clk);
    ifu_req_valid = iv; ifu_addr = ia; lsu_req_valid = lv; lsu_addr = la;
    lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    win  = pick(iv, lv, last_m, 1'b1);
    fwin = pick(iv, lv, 0, 1'b0);
    #1;
    got = lsu_req_ready ? 1 : 0;
    tests++;
    if ({lsu_req_ready, ifu_req_ready} !== ((win == 1) ? 2'b10 : 2'b01)) begin
      fails++;
      $display("FAIL grant: ready{lsu,ifu}=%b expected %b", {lsu_req_ready, ifu_req_ready}, (win == 1) ? 2'b10 : 2'b01);
    end
    tests++;
    if ({fp_lsu_req_ready, fp_ifu_req_ready} !== ((fwin == 1) ? 2'b10 : 2'b01)) begin
      fails++;
      $display("FAIL fp_grant: ready{lsu,ifu}=%b expected %b", {fp_lsu_req_ready, fp_ifu_req_ready}, (fwin == 1) ? 2'b10 : 2'b01);
    end
    last_m = win;
    ea   = (win == 1) ? la : ia;
    ewen = (win == 1) ? wen : 1'b0;
    ewm  = (win == 1) ? wm : 4'b0;

    for (int i = 0; i <= req_lat; i++) begin
      @(negedge clk);
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
      mem_req_ready = (i == req_lat);
      #1;
      tests++;
      if ({mem_req_valid, mem_addr, mem_wen, mem_wmask} !== {1'b1, ea, ewen, ewm}) begin
        fails++;
        $display("FAIL req_fields: {v,addr,wen,wmask}=%b,%h,%b,%b expected 1,%h,%b,%b",
                 mem_req_valid, mem_addr, mem_wen, mem_wmask, ea, ewen, ewm);
      end
      if (win == 1) begin
        tests++;
        if (mem_wdata !== wd) begin
          fails++;
          $display("FAIL req_wdata: got %h expected %h", mem_wdata, wd);
        end
      end
      tests++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
        fails++;
        $display("FAIL busy_ready_req: got %b expected 00", {ifu_req_ready, lsu_req_ready});
      end
    end

    for (int i = 0; i <= resp_lat + rdy_lat; i++) begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      ov   = (i >= resp_lat);
      ordy = (i == resp_lat + rdy_lat);
      mem_resp_valid = ov;
      mem_rdata = ov ? rd : 32'($urandom);
      mem_err   = ov ? er : 1'b0;
      ifu_resp_ready = ordy; lsu_resp_ready = ordy;
      #1;
      o_v = (win == 1) ? lsu_resp_valid : ifu_resp_valid;
      o_d = (win == 1) ? lsu_rdata : ifu_rdata;
      o_e = (win == 1) ? lsu_err : ifu_err;
      n_v = (win == 1) ? ifu_resp_valid : lsu_resp_valid;
      n_d = (win == 1) ? ifu_rdata : lsu_rdata;
      n_e = (win == 1) ? ifu_err : lsu_err;
      tests++;
      if (o_v !== ov) begin
        fails++;
        $display("FAIL owner_valid: got %b expected %b", o_v, ov);
      end
      if (ov) begin
        tests++;
        if ({o_d, o_e} !== {rd, er}) begin
          fails++;
          $display("FAIL owner_data: {rdata,err}=%h,%b expected %h,%b", o_d, o_e, rd, er);
        end
      end
      tests++;
      if ({n_v, n_d, n_e} !== 34'd0) begin
        fails++;
        $display("FAIL nonowner: {valid,rdata,err}=%b,%h,%b expected all 0", n_v, n_d, n_e);
      end
      tests++;
      if (mem_resp_ready !== ordy) begin
        fails++;
        $display("FAIL mem_resp_ready: got %b expected %b", mem_resp_ready, ordy);
      end
      tests++;
      if ({mem_req_valid, ifu_req_ready, lsu_req_ready} !== 3'b000) begin
        fails++;
        $display("FAIL busy_resp: {mem_req_valid,ifu_rdy,lsu_rdy}=%b expected 000", {mem_req_valid, ifu_req_ready, lsu_req_ready});
      end
    end
    $display("[TB] txn iv=%b lv=%b granted=%s addr=%h", iv, lv, (win == 1) ? "LSU" : "IFU", ea);
  endtask

  task automatic test_reset();
    drive_quiet();
    rst = 1'b0;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready} !== 6'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready});
    end
    tests++;
    if ({ifu_rdata, lsu_rdata, ifu_err, lsu_err, mem_addr, mem_wen, mem_wdata, mem_wmask} !== 135'd0) begin
      fails++;
      $display("FAIL reset_data: ifu_rdata=%h lsu_rdata=%h mem_addr=%h mem_wdata=%h expected all 0",
               ifu_rdata, lsu_rdata, mem_addr, mem_wdata);
    end
    drive_quiet();
    rst = 1'b1;
    last_m = 0;
    $display("[TB] reset checked");
  endtask

  task automatic test_tie();
    logic [3:0] exp_seq;
    int got;
    exp_seq = 4'b1010;  // LSU, IFU, LSU, IFU from reset
    for (int k = 0; k < 4; k++) begin
      txn(1'b1, 1'b1, 32'h8000_0100 + 32'(k * 4), 32'h8000_2000 + 32'(k * 4), 1'b0, 32'h0, 4'h0,
          0, 0, 0, 32'h1000 + 32'(k), 1'b0, got);
      tests++;
      if (got !== int'(exp_seq[3-k])) begin
        fails++;
        $display("FAIL tie_order[%0d]: granted %0d expected %0d (1=LSU)", k, got, exp_seq[3-k]);
      end
    end
  endtask

  task automatic test_lone_ifu();
    int got;
    txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0, 0, 2, 0, 32'h0000_0413, 1'b0, got);
  endtask

  task automatic test_lsu_write();
    int got;
    txn(1'b0, 1'b1, 32'h0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011, 3, 1, 0, 32'h0, 1'b0, got);
  endtask

  task automatic test_back_pressure();
    int got;
    txn(1'b1, 1'b0, 32'h8000_0040, 32'h0, 1'b0, 32'h0, 4'h0, 0, 1, 4, 32'hCAFE_F00D, 1'b0, got);
    txn(1'b0, 1'b1, 32'h0, 32'h8000_0080, 1'b0, 32'h0, 4'h0, 1, 0, 4, 32'h1234_5678, 1'b1, got);
  endtask

  task automatic test_random();
    logic [1:0] r;
    int got;
    for (int k = 0; k < 30; k++) begin
      r = 2'($urandom_range(1, 3));
      txn(r[0], r[1], 32'($urandom) & 32'hFFFF_FFFC, 32'($urandom), 1'($urandom), 32'($urandom), 4'($urandom),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          32'($urandom), 1'($urandom), got);
    end
  endtask

  task automatic test_timeout();
    int got;
    @(negedge clk);
    drive_quiet();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    #1;
    tests++;
    if (lsu_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL wdog_grant: lsu_req_ready=%b expected 1", lsu_req_ready);
    end
    last_m = 1;
    @(negedge clk);
    ifu_req_valid = 1'b1; mem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_req_ready = 1'b0; mem_rdata = 32'($urandom);
      #1;
      tests++;
      if ({lsu_resp_valid, ifu_resp_valid} !== 2'b00) begin
        fails++;
        $display("FAIL wdog_early[%0d]: {lsu,ifu}_resp_valid=%b expected 00", i, {lsu_resp_valid, ifu_resp_valid});
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_rdata = 32'hFFFF_FFFF;
      #1;
      tests++;
      if ({lsu_resp_valid, lsu_err, lsu_rdata, ifu_resp_valid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
        fails++;
        $display("FAIL wdog_err[%0d]: lsu valid=%b err=%b rdata=%h ifu_valid=%b expected 1,1,0,0",
                 i, lsu_resp_valid, lsu_err, lsu_rdata, ifu_resp_valid);
      end
    end
    lsu_resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      tests++;
      if ({mem_resp_ready, lsu_resp_valid, ifu_req_ready, lsu_req_ready} !== 4'b1000) begin
        fails++;
        $display("FAIL drain[%0d]: {mem_resp_ready,lsu_valid,ifu_rdy,lsu_rdy}=%b expected 1000",
                 i, {mem_resp_ready, lsu_resp_valid, ifu_req_ready, lsu_req_ready});
      end
    end
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_rdata = 32'h0BAD_0BAD; mem_err = 1'b1;
    #1;
    tests++;
    if ({mem_resp_ready, lsu_resp_valid, ifu_resp_valid} !== 3'b100) begin
      fails++;
      $display("FAIL drain_swallow: {mem_resp_ready,lsu_valid,ifu_valid}=%b expected 100",
               {mem_resp_ready, lsu_resp_valid, ifu_resp_valid});
    end
    $display("[TB] watchdog timeout and drain checked");
    txn(1'b1, 1'b0, 32'h8000_0200, 32'h0, 1'b0, 32'h0, 4'h0, 0, 1, 0, 32'h0000_0013, 1'b0, got);
  endtask

  task automatic test_reset_mid();
    int got;
    @(negedge clk);
    drive_quiet();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b1; lsu_wdata = 32'h5555_AAAA; lsu_wmask = 4'hF;
    last_m = 1;
    @(negedge clk);
    #1;
    tests++;
    if (mem_req_valid !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_in_req: mem_req_valid=%b expected 1", mem_req_valid);
    end
    rst = 1'b0; ifu_req_valid = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready, mem_addr, mem_wen, mem_wdata, mem_wmask} !== 74'd0) begin
      fails++;
      $display("FAIL rstmid_state: req_v=%b resp_v=%b%b rdy=%b%b mem_addr=%h wdata=%h expected all 0",
               mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready, mem_addr, mem_wdata);
    end
    rst = 1'b1;
    last_m = 0;
    #1;
    tests++;
    if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
      fails++;
      $display("FAIL rstmid_last_grant: ready{lsu,ifu}=%b expected 10", {lsu_req_ready, ifu_req_ready});
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    $display("[TB] reset during REQ checked");
    txn(1'b1, 1'b1, 32'h8000_0300, 32'h8000_3300, 1'b0, 32'h0, 4'h0, 0, 0, 0, 32'h7777_0000, 1'b0, got);
    txn(1'b1, 1'b1, 32'h8000_0304, 32'h8000_3304, 1'b0, 32'h0, 4'h0, 1, 1, 1, 32'h7777_0001, 1'b0, got);
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    ifu_addr = '0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    drive_quiet();
    test_reset();
    test_tie();
    test_lone_ifu();
    test_lsu_write();
    test_back_pressure();
    test_random();
    test_timeout();
    test_reset_mid();
    @(negedge clk);
    drive_quiet();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
